// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers:
// state encoding, operand width bounds and counter sizing.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // Bits needed to count 0..w-1, never less than one.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full-adder cell shared by the serial controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH
// clocks, LSB first, with a start/busy/done handshake and abort.
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             cell_s;
    logic             cell_c;
    logic [WIDTH-1:0] res_next;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_reg),
        .s  (cell_s),
        .co (cell_c)
    );

    // Partial result: the cell sum enters at the MSB and earlier bits move
    // right. Only WIDTH-1 bits ever need storing, since the final bit goes
    // straight from the cell into the result register.
    if (WIDTH == 1) begin : g_res_w1
        assign res_next = cell_s;
    end else begin : g_res_wn
        logic [WIDTH-2:0] res_sr;

        assign res_next = {cell_s, res_sr};

        // Shift the partial result once per processed bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_sr <= '0;
            end else if (state_reg == RUN && !abort) begin
                res_sr <= res_next[WIDTH-1:1];
            end
        end
    end

    // Sequencer: operand capture, per-bit shifting, completion and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sr      <= a;
                        b_sr      <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        a_sr      <= a_sr >> 1;
                        b_sr      <= b_sr >> 1;
                        carry_reg <= cell_c;
                        if (cnt_reg == LAST) begin
                            sum_reg   <= res_next;
                            cout_reg  <= cell_c;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed vectors and corner sequences at
// WIDTH=8, random sweeps at WIDTH=1 and WIDTH=16 against a + b + cin.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 0, abort8 = 0, cin8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    // WIDTH=1 instance
    logic       start1 = 0, abort1 = 0, cin1 = 0;
    logic [0:0] a1 = 0, b1 = 0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    // WIDTH=16 instance
    logic        start16 = 0, abort16 = 0, cin16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16),
        .a(a16), .b(b16), .cin(cin16), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] last_sum8 = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One WIDTH=8 operation from an IDLE negedge; optionally holds start high
    // with different operands through RUN and the done cycle.
    task automatic op8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [7:0] es, input logic ec,
                       input logic inj_start);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = inj_start;
        a8 = 8'h55; b8 = 8'h55; cin8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk({name, "_busy"}, 64'({busy8, done8}), 64'(2'b10));
            chk({name, "_hold"}, 64'(sum8), 64'(last_sum8));
            @(negedge clk);
        end
        chk({name, "_done"}, 64'({busy8, done8}), 64'(2'b01));
        chk({name, "_result"}, 64'({cout8, sum8}), 64'({ec, es}));
        @(negedge clk);
        start8 = 1'b0;
        chk({name, "_idle"}, 64'({busy8, done8}), 64'(2'b00));
        last_sum8 = sum8;
        $display("op %s a=%h b=%h cin=%b -> sum=%h cout=%b", name, ta, tb_, tc, sum8, cout8);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        // Reset state of all instances
        #12;
        chk("rst_w8", 64'({busy8, done8, cout8, sum8}), 64'(0));
        chk("rst_w1", 64'({busy1, done1, cout1, sum1}), 64'(0));
        chk("rst_w16", 64'({busy16, done16, cout16, sum16}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].s, vecs[i].c, 1'b0);
        end

        // Start held through RUN and done cycle is ignored; restart at edge 10
        op8("ign", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);
        op8("restart", 8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b0);
        op8("prior", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // Abort on edge 4
        begin
            int dcount;
            a8 = 8'h33; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            repeat (3) @(negedge clk);
            abort8 = 1'b1;
            @(negedge clk);
            abort8 = 1'b0;
            chk("abort_state", 64'({busy8, done8}), 64'(2'b00));
            chk("abort_sum", 64'({cout8, sum8}), 64'({1'b0, 8'h10}));
            dcount = 0;
            for (int k = 0; k < 12; k++) begin
                if (done8 || busy8) dcount++;
                @(negedge clk);
            end
            chk("abort_no_done", 64'(dcount), 64'(0));
            $display("op abort a=33 b=11 -> sum=%h", sum8);
        end

        // Asynchronous reset during RUN (after edge 5)
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({busy8, done8, cout8, sum8}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_sum8 = 8'h00;
        @(negedge clk);
        op8("after_rst", 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);

        // Random sweeps on the narrow and wide instances in parallel
        fork
            begin : sweep16
                logic [15:0] ra, rb;
                logic        rc;
                logic [16:0] expv;
                int          n;
                for (int i = 0; i < 1000; i++) begin
                    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
                    expv = 17'(ra) + 17'(rb) + 17'(rc);
                    a16 = ra; b16 = rb; cin16 = rc; start16 = 1'b1;
                    @(negedge clk);
                    n = 1;
                    while (done16 !== 1'b1 && n <= 20) begin
                        start16 = 1'($urandom_range(0, 1));
                        a16 = 16'($urandom); b16 = 16'($urandom);
                        @(negedge clk);
                        n++;
                    end
                    chk("w16_latency", 64'(n), 64'(17));
                    chk("w16_result", 64'({cout16, sum16}), 64'(expv));
                    $display("w16 op %0d a=%h b=%h cin=%b sum=%h cout=%b lat=%0d",
                             i, ra, rb, rc, sum16, cout16, n);
                    start16 = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    start16 = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin : sweep1
                logic       qa, qb, qc;
                logic [1:0] expq;
                int         m;
                for (int j = 0; j < 1000; j++) begin
                    qa = 1'($urandom_range(0, 1)); qb = 1'($urandom_range(0, 1));
                    qc = 1'($urandom_range(0, 1));
                    expq = 2'(qa) + 2'(qb) + 2'(qc);
                    a1 = qa; b1 = qb; cin1 = qc; start1 = 1'b1;
                    @(negedge clk);
                    m = 1;
                    while (done1 !== 1'b1 && m <= 5) begin
                        start1 = 1'($urandom_range(0, 1));
                        a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
                        @(negedge clk);
                        m++;
                    end
                    chk("w1_latency", 64'(m), 64'(2));
                    chk("w1_result", 64'({cout1, sum1}), 64'(expq));
                    $display("w1 op %0d a=%b b=%b cin=%b sum=%b cout=%b lat=%0d",
                             j, qa, qb, qc, sum1, cout1, m);
                    start1 = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    start1 = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
